// File: rtl/datapath_ctrl.sv
// Multi-cycle sequencer for the datapath: accepts one decoded instruction on a
// start/wait handshake and drives the register-file, A/B/C, shifter and ALU controls.
module datapath_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [2:0]  opcode,
  input  logic [1:0]  op,
  input  logic [2:0]  rn,
  input  logic [2:0]  rd,
  input  logic [2:0]  rm,
  input  logic [1:0]  sh,
  input  logic [15:0] imm16,
  output logic        w,
  output logic        done,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic        loadc,
  output logic        loads,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] datapath_in
);

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_WR_IMM = 3'd1,
    ST_GET_A  = 3'd2,
    ST_GET_B  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WR_REG = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  opcode_q, opcode_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  rn_q, rn_d;
  logic [2:0]  rd_q, rd_d;
  logic [2:0]  rm_q, rm_d;
  logic [1:0]  sh_q, sh_d;
  logic [15:0] imm_q, imm_d;

  logic in_supported;
  logic accept;
  logic in_mov_imm;
  logic in_skip_a;

  logic is_mov_reg;
  logic is_cmp;
  logic is_mvn;

  logic write_raw;
  logic loada_raw;
  logic loadb_raw;
  logic loadc_raw;
  logic loads_raw;

  // Decode of the live inputs, used only while sitting in WAIT.
  always_comb begin
    in_supported = ((opcode == OPC_MOV) && ((op == 2'b10) || (op == 2'b00))) ||
                   (opcode == OPC_ALU);
    accept       = (state_q == ST_WAIT) && s && in_supported;
    in_mov_imm   = (opcode == OPC_MOV) && (op == 2'b10);
    in_skip_a    = (opcode == OPC_MOV) || (op == 2'b11);
  end

  // Decode of the latched fields, used in every active state.
  always_comb begin
    is_mov_reg = (opcode_q == OPC_MOV) && (op_q == 2'b00);
    is_cmp     = (opcode_q == OPC_ALU) && (op_q == 2'b01);
    is_mvn     = (opcode_q == OPC_ALU) && (op_q == 2'b11);
  end

  always_comb begin
    opcode_d = opcode_q;
    op_d     = op_q;
    rn_d     = rn_q;
    rd_d     = rd_q;
    rm_d     = rm_q;
    sh_d     = sh_q;
    imm_d    = imm_q;
    if (accept) begin
      opcode_d = opcode;
      op_d     = op;
      rn_d     = rn;
      rd_d     = rd;
      rm_d     = rm;
      sh_d     = sh;
      imm_d    = imm16;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_WAIT;
      opcode_q <= '0;
      op_q     <= '0;
      rn_q     <= '0;
      rd_q     <= '0;
      rm_q     <= '0;
      sh_q     <= '0;
      imm_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      op_q     <= op_d;
      rn_q     <= rn_d;
      rd_q     <= rd_d;
      rm_q     <= rm_d;
      sh_q     <= sh_d;
      imm_q    <= imm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAIT: begin
        if (accept) begin
          if (in_mov_imm)     state_d = ST_WR_IMM;
          else if (in_skip_a) state_d = ST_GET_B;
          else                state_d = ST_GET_A;
        end
      end
      ST_WR_IMM: state_d = ST_WAIT;
      ST_GET_A:  state_d = ST_GET_B;
      ST_GET_B:  state_d = ST_EXEC;
      ST_EXEC:   state_d = is_cmp ? ST_WAIT : ST_WR_REG;
      ST_WR_REG: state_d = ST_WAIT;
      default:   state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    w         = 1'b0;
    done      = 1'b0;
    readnum   = 3'd0;
    writenum  = 3'd0;
    write_raw = 1'b0;
    vsel      = 1'b0;
    loada_raw = 1'b0;
    loadb_raw = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    loadc_raw = 1'b0;
    loads_raw = 1'b0;
    shift     = 2'b00;
    ALUop     = 2'b00;
    unique case (state_q)
      ST_WAIT: w = 1'b1;
      ST_WR_IMM: begin
        writenum  = rn_q;
        vsel      = 1'b1;
        write_raw = 1'b1;
        done      = 1'b1;
      end
      ST_GET_A: begin
        readnum   = rn_q;
        loada_raw = 1'b1;
      end
      ST_GET_B: begin
        readnum   = rm_q;
        loadb_raw = 1'b1;
      end
      ST_EXEC: begin
        shift = sh_q;
        if (is_mov_reg || is_mvn) begin
          // Zeroing A turns the ALU into a pass-through / invert of shifted B.
          asel      = 1'b1;
          ALUop     = is_mvn ? 2'b11 : 2'b00;
          loadc_raw = 1'b1;
        end else if (is_cmp) begin
          ALUop     = 2'b01;
          loads_raw = 1'b1;
          done      = 1'b1;
        end else begin
          ALUop     = op_q;
          loadc_raw = 1'b1;
        end
      end
      ST_WR_REG: begin
        writenum  = rd_q;
        write_raw = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are masked by reset so an abandoned instruction never commits.
  always_comb begin
    write       = write_raw & ~reset;
    loada       = loada_raw & ~reset;
    loadb       = loadb_raw & ~reset;
    loadc       = loadc_raw & ~reset;
    loads       = loads_raw & ~reset;
    datapath_in = imm_q;
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl: a small datapath model follows the control
// outputs so register results and per-instruction handshake timing can be checked.
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [2:0]  rn, rd, rm;
  logic [1:0]  sh;
  logic [15:0] imm16;
  logic        w, done;
  logic [2:0]  readnum, writenum;
  logic        write, vsel, loada, loadb, asel, bsel, loadc, loads;
  logic [1:0]  shift, ALUop;
  logic [15:0] datapath_in;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  datapath_ctrl dut (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .rn(rn), .rd(rd), .rm(rm), .sh(sh), .imm16(imm16),
    .w(w), .done(done), .readnum(readnum), .writenum(writenum),
    .write(write), .vsel(vsel), .loada(loada), .loadb(loadb),
    .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads),
    .shift(shift), .ALUop(ALUop), .datapath_in(datapath_in)
  );

  // Datapath model driven by the controller outputs.
  logic [15:0] rf [8] = '{default: 16'h0000};
  logic [15:0] a_q = 16'h0, b_q = 16'h0, c_q = 16'h0;
  logic        z_q = 1'b0;
  logic [15:0] sh_out, ain, bin, alu;

  always_comb begin
    case (shift)
      2'b00:   sh_out = b_q;
      2'b01:   sh_out = b_q << 1;
      2'b10:   sh_out = b_q >> 1;
      default: sh_out = {b_q[15], b_q[15:1]};
    endcase
    ain = asel ? 16'h0 : a_q;
    bin = bsel ? datapath_in : sh_out;
    case (ALUop)
      2'b00:   alu = ain + bin;
      2'b01:   alu = ain - bin;
      2'b10:   alu = ain & bin;
      default: alu = ~bin;
    endcase
  end

  always @(posedge clk) begin
    if (write) rf[writenum] <= vsel ? datapath_in : c_q;
    if (loada) a_q <= rf[readnum];
    if (loadb) b_q <= rf[readnum];
    if (loadc) c_q <= alu;
    if (loads) z_q <= (alu == 16'h0);
  end

  logic [19:0] ctrl_vec;
  assign ctrl_vec = {w, done, readnum, writenum, write, vsel, loada, loadb,
                     asel, bsel, loadc, loads, shift, ALUop};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_instr(input string name, input logic [2:0] opc, input logic [1:0] o,
                          input logic [2:0] n, input logic [2:0] d, input logic [2:0] m,
                          input logic [1:0] shf, input logic [15:0] imm,
                          input int exp_lat, input bit mid_pulse);
    int cycles = 0, done_cnt = 0, wr_cnt = 0, lds_cnt = 0;
    bit last_done = 1'b0;
    bit is_cmp = (opc == 3'b101) && (o == 2'b01);
    opcode = opc; op = o; rn = n; rd = d; rm = m; sh = shf; imm16 = imm;
    s = 1'b1;
    tick();
    s = 1'b0;
    while (!w && cycles < 10) begin
      if (mid_pulse && cycles == 1) begin
        s = 1'b1; opcode = 3'b110; op = 2'b10; rn = 3'd2; imm16 = 16'h0099;
      end else begin
        s = 1'b0;
      end
      cycles++;
      done_cnt  += int'(done);
      wr_cnt    += int'(write);
      lds_cnt   += int'(loads);
      last_done  = done;
      tick();
    end
    s = 1'b0;
    check({name, "_latency"}, cycles, exp_lat);
    check({name, "_done_cnt"}, done_cnt, 1);
    check({name, "_done_last"}, last_done, 1);
    check({name, "_writes"}, wr_cnt, is_cmp ? 0 : 1);
    check({name, "_loads"}, lds_cnt, is_cmp ? 1 : 0);
    $display("%s: w low %0d cycles, done=%0d, writes=%0d", name, cycles, done_cnt, wr_cnt);
  endtask

  initial begin
    reset = 1'b1; s = 1'b0; opcode = 3'b101; op = 2'b11;
    rn = 3'd7; rd = 3'd7; rm = 3'd7; sh = 2'b11; imm16 = 16'hBEEF;
    tick();
    tick();
    reset = 1'b0;
    check("reset_ctrl", ctrl_vec, 20'h80000);
    check("reset_din", datapath_in, 16'h0000);
    $display("reset: w=%0d done=%0d", w, done);

    do_instr("mov_r3_imm", 3'b110, 2'b10, 3'd3, 3'd0, 3'd0, 2'b00, 16'h0042, 1, 1'b0);
    check("r3", rf[3], 16'h0042);
    do_instr("mov_r5_imm", 3'b110, 2'b10, 3'd5, 3'd0, 3'd0, 2'b00, 16'h0013, 1, 1'b0);
    check("r5", rf[5], 16'h0013);

    do_instr("add_r2", 3'b101, 2'b00, 3'd5, 3'd2, 3'd3, 2'b00, 16'h0000, 4, 1'b0);
    check("add_r2", rf[2], 16'h0055);
    check("add_c", c_q, 16'h0055);
    check("add_z", z_q, 1'b0);
    check("add_r3_kept", rf[3], 16'h0042);
    check("add_r5_kept", rf[5], 16'h0013);

    do_instr("cmp_r3_r3", 3'b101, 2'b01, 3'd3, 3'd0, 3'd3, 2'b00, 16'h0000, 3, 1'b0);
    check("cmp_z", z_q, 1'b1);

    do_instr("mvn_r1", 3'b101, 2'b11, 3'd0, 3'd1, 3'd3, 2'b00, 16'h0000, 3, 1'b0);
    check("mvn_r1", rf[1], 16'hFFBD);

    do_instr("mov_r4_r3_lsl", 3'b110, 2'b00, 3'd0, 3'd4, 3'd3, 2'b01, 16'h0000, 3, 1'b0);
    check("mov_r4", rf[4], 16'h0084);

    do_instr("and_r7", 3'b101, 2'b10, 3'd5, 3'd7, 3'd3, 2'b00, 16'h0000, 4, 1'b0);
    check("and_r7", rf[7], 16'h0002);

    // Unsupported encodings are ignored.
    opcode = 3'b111; op = 2'b00; rn = 3'd2; imm16 = 16'h0777; s = 1'b1;
    tick();
    s = 1'b0;
    check("bad111_w", w, 1'b1);
    check("bad111_done", done, 1'b0);
    opcode = 3'b110; op = 2'b01; s = 1'b1;
    tick();
    s = 1'b0;
    check("bad110_01_w", w, 1'b1);
    tick();
    check("bad_r2_kept", rf[2], 16'h0055);
    $display("unsupported encodings: w=%0d done=%0d", w, done);

    do_instr("add_r2_midpulse", 3'b101, 2'b00, 3'd5, 3'd2, 3'd3, 2'b00, 16'h0000, 4, 1'b1);
    check("midpulse_r2", rf[2], 16'h0055);

    do_instr("mov_r6_imm", 3'b110, 2'b10, 3'd6, 3'd0, 3'd0, 2'b00, 16'h0077, 1, 1'b0);
    check("r6_init", rf[6], 16'h0077);

    // Abandon ADD R6,R5,R3 with reset while it sits in WR_REG.
    opcode = 3'b101; op = 2'b00; rn = 3'd5; rd = 3'd6; rm = 3'd3; sh = 2'b00; s = 1'b1;
    tick();
    s = 1'b0;
    repeat (3) tick();
    check("wrreg_write", write, 1'b1);
    check("wrreg_writenum", writenum, 3'd6);
    reset = 1'b1;
    #1;
    check("reset_gates_write", write, 1'b0);
    tick();
    reset = 1'b0;
    check("midreset_ctrl", ctrl_vec, 20'h80000);
    check("midreset_din", datapath_in, 16'h0000);
    check("midreset_r6", rf[6], 16'h0077);
    $display("reset in WR_REG: r6=0x%04h w=%0d", rf[6], w);

    do_instr("mov_r0_imm", 3'b110, 2'b10, 3'd0, 3'd0, 3'd0, 2'b00, 16'h1234, 1, 1'b0);
    check("r0", rf[0], 16'h1234);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
